wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 64, width of the retired-instruction counter; data width is DATA_WIDTH from my_pkg (32).
REQ-002 SHALL have ports in this order:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  MEM-stage entry present.
- in_ready  out  1  WB accepts entry; equals ~stall.
- stall  in  1  block capture this cycle.
- flush  in  1  discard capture this cycle.
- wb_sel  in  2  write-back source, wb_sel_t.
- mem_funct3  in  3  load type.
- addr_lo  in  2  load address bits [1:0].
- reg_write  in  1  instruction writes rd.
- rd_addr  in  5  destination register.
- data_alu_result  in  DATA_WIDTH  ALU result.
- data_mem_read  in  DATA_WIDTH  raw memory word.
- pc_plus4  in  DATA_WIDTH  link value.
- data_csr  in  DATA_WIDTH  CSR read data; present only with WB_CSR_EN.
- instret_clr  in  1  synchronous counter clear.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  DATA_WIDTH  register-file write data.
- load_misalign  out  1  misaligned-load pulse.
- instret  out  CNT_WIDTH  retired-instruction count.

Function
REQ-003 SHALL capture all inputs into one WB register on the clk edge when in_valid & in_ready & ~flush; latency input-to-rf_we is exactly 1 cycle.
REQ-004 SHALL clear valid_q on any edge without capture (stall, flush, or ~in_valid), so each entry is presented for exactly one cycle.
REQ-005 SHALL give flush priority over capture when flush and in_valid are both high.
REQ-006 SHALL drive rf_wdata combinationally from registered fields: WB_ALU=alu, WB_MEM=extracted load, WB_PC4=pc_plus4, WB_CSR=per REQ-016.
REQ-007 SHALL extract loads by mem_funct3 and addr_lo: 000 LB sign-extended byte; 001 LH sign-extended half; 010 LW word; 100 LBU zero-extended byte; 101 LHU zero-extended half; other codes give 0.
REQ-008 SHALL select byte lane addr_lo and half lane addr_lo[1] (little-endian).
REQ-009 SHALL assert load_misalign when valid_q & wb_sel==WB_MEM and (halfword with addr_lo[0]=1, or LW with addr_lo!=0).
REQ-010 SHALL drive rf_we = valid_q & reg_write_q & (rd_q!=0) & ~load_misalign; rf_waddr = rd_q.
REQ-011 SHALL increment instret when valid_q & ~load_misalign, wrapping from all-ones to 0.
REQ-012 SHALL, when instret_clr and a retire coincide, load instret with 0; clear wins.

Reset
REQ-013 SHALL, on rst_n low and independent of clk, clear valid_q, all captured fields and instret; rf_we=0, rf_waddr=0, rf_wdata=0, load_misalign=0, instret=0.
REQ-014 SHALL, on reset mid-operation, drop the held entry with no register-file write.
REQ-015 SHALL resume capture on the first clk edge after rst_n deasserts.

Configuration
REQ-016 SHALL, with macro WB_CSR_EN defined, provide port data_csr, with WB_CSR selecting it; without the macro, data_csr SHALL be absent and WB_CSR SHALL select the ALU result.

Structure
REQ-017 SHALL place DATA_WIDTH, enum wb_sel_t (WB_ALU=0, WB_MEM=1, WB_PC4=2, WB_CSR=3) and load funct3 constants in my_pkg.
REQ-018 SHALL implement lane extraction and sign/zero extension in a combinational sub-module load_ext.

Verification
REQ-019 LB, data_mem_read=0x8070_60F0, addr_lo=0, rd=5, WB_MEM -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xFFFF_FFF0.
REQ-020 LHU, addr_lo=2, mem 0x8070_60F0 -> rf_wdata=0x0000_8070; LW addr_lo=1 -> load_misalign=1, rf_we=0, instret unchanged.
REQ-021 WB_PC4, pc_plus4=0x104, rd=0 -> rf_we=0; instret +1.
REQ-022 in_valid=1 with stall=1, then with flush=1 -> rf_we=0 both following cycles, instret unchanged.
REQ-023 instret preset to all-ones via retires near wrap (CNT_WIDTH=4, 15 retires then 1) -> 0; instret_clr with retire -> 0.
REQ-024 rst_n low mid-stream with valid_q=1 -> rf_we=0 and instret=0 immediately, without a clk edge; WB_CSR with and without WB_CSR_EN -> data_csr vs alu result.

Source files
------------

// File: rtl/my_pkg.sv
// Shared write-back types: data width, write-back source select, load funct3 codes and the captured-entry record.
// The data_csr field of wb_meta_t is present only when WB_CSR_EN is defined.
package my_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    wb_sel_t                 wb_sel;
    logic [2:0]              mem_funct3;
    logic [1:0]              addr_lo;
    logic                    reg_write;
    logic [4:0]              rd_addr;
    logic [DATA_WIDTH-1:0]   data_alu_result;
    logic [DATA_WIDTH-1:0]   data_mem_read;
    logic [DATA_WIDTH-1:0]   pc_plus4;
`ifdef WB_CSR_EN
    logic [DATA_WIDTH-1:0]   data_csr;
`endif
  } wb_meta_t;

  // Byte loads never misalign; halfwords need an even address, words need addr_lo == 0.
  function automatic logic load_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if ((funct3 == F3_LH) || (funct3 == F3_LHU)) begin
      mis = addr_lo[0];
    end else if (funct3 == F3_LW) begin
      mis = (addr_lo != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/load_ext.sv
// Load lane extraction with sign/zero extension, little-endian lanes; purely combinational, 0 latency, no flow control.
// Byte lane chosen by addr_lo, halfword lane by addr_lo[1]; unsupported funct3 codes return zero.
module load_ext
  import my_pkg::*;
(
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[7:0];
    case (addr_lo)
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase
  end

  assign half_lane = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = '0;
    case (funct3)
      F3_LB:   data = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
      F3_LH:   data = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
      F3_LW:   data = word;
      F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
      F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, half_lane};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: one capture register, 1-cycle input-to-rf_we latency; in_ready = ~stall, flush discards the capture.
// Optional WB_CSR_EN macro adds the data_csr port and makes WB_CSR select it (otherwise WB_CSR selects the ALU result).
module wb_stage
  import my_pkg::*;
#(
  parameter int CNT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  stall,
  input  logic                  flush,
  input  wb_sel_t               wb_sel,
  input  logic [2:0]            mem_funct3,
  input  logic [1:0]            addr_lo,
  input  logic                  reg_write,
  input  logic [4:0]            rd_addr,
  input  logic [DATA_WIDTH-1:0] data_alu_result,
  input  logic [DATA_WIDTH-1:0] data_mem_read,
  input  logic [DATA_WIDTH-1:0] pc_plus4,
`ifdef WB_CSR_EN
  input  logic [DATA_WIDTH-1:0] data_csr,
`endif
  input  logic                  instret_clr,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  load_misalign,
  output logic [CNT_WIDTH-1:0]  instret
);

  wb_meta_t              meta_d;
  wb_meta_t              meta_q;
  logic                  valid_q;
  logic                  capture;
  logic                  retire;
  logic [DATA_WIDTH-1:0] load_data;

  assign in_ready = ~stall;
  // Flush outranks capture even when the upstream entry is valid and not stalled.
  assign capture  = in_valid & in_ready & ~flush;

  always_comb begin
    meta_d                 = '0;
    meta_d.wb_sel          = wb_sel;
    meta_d.mem_funct3      = mem_funct3;
    meta_d.addr_lo         = addr_lo;
    meta_d.reg_write       = reg_write;
    meta_d.rd_addr         = rd_addr;
    meta_d.data_alu_result = data_alu_result;
    meta_d.data_mem_read   = data_mem_read;
    meta_d.pc_plus4        = pc_plus4;
`ifdef WB_CSR_EN
    meta_d.data_csr        = data_csr;
`endif
  end

  // valid_q drops on every non-capturing edge, so each entry is presented exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      meta_q  <= '0;
    end else begin
      valid_q <= capture;
      if (capture) begin
        meta_q <= meta_d;
      end
    end
  end

  load_ext u_load_ext (
    .funct3  (meta_q.mem_funct3),
    .addr_lo (meta_q.addr_lo),
    .word    (meta_q.data_mem_read),
    .data    (load_data)
  );

  always_comb begin
    rf_wdata = meta_q.data_alu_result;
    case (meta_q.wb_sel)
      WB_ALU:  rf_wdata = meta_q.data_alu_result;
      WB_MEM:  rf_wdata = load_data;
      WB_PC4:  rf_wdata = meta_q.pc_plus4;
`ifdef WB_CSR_EN
      WB_CSR:  rf_wdata = meta_q.data_csr;
`else
      WB_CSR:  rf_wdata = meta_q.data_alu_result;
`endif
      default: rf_wdata = meta_q.data_alu_result;
    endcase
  end

  assign load_misalign = valid_q & (meta_q.wb_sel == WB_MEM)
                       & load_misaligned(meta_q.mem_funct3, meta_q.addr_lo);

  // x0 is hard-wired zero, and a misaligned load must not commit.
  assign rf_we    = valid_q & meta_q.reg_write & (meta_q.rd_addr != 5'd0) & ~load_misalign;
  assign rf_waddr = meta_q.rd_addr;
  assign retire   = valid_q & ~load_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (instret_clr) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for data-path cases, hand sequences for stall/flush, wrap, clear and reset.
module tb_wb_stage;
  import my_pkg::*;

  localparam int CW = 4;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic                  stall;
  logic                  flush;
  wb_sel_t               wb_sel;
  logic [2:0]            mem_funct3;
  logic [1:0]            addr_lo;
  logic                  reg_write;
  logic [4:0]            rd_addr;
  logic [DATA_WIDTH-1:0] data_alu_result;
  logic [DATA_WIDTH-1:0] data_mem_read;
  logic [DATA_WIDTH-1:0] pc_plus4;
`ifdef WB_CSR_EN
  logic [DATA_WIDTH-1:0] data_csr;
`endif
  logic                  instret_clr;
  logic                  rf_we;
  logic [4:0]            rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  load_misalign;
  logic [CW-1:0]         instret;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_cnt;

  wb_stage #(.CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .stall           (stall),
    .flush           (flush),
    .wb_sel          (wb_sel),
    .mem_funct3      (mem_funct3),
    .addr_lo         (addr_lo),
    .reg_write       (reg_write),
    .rd_addr         (rd_addr),
    .data_alu_result (data_alu_result),
    .data_mem_read   (data_mem_read),
    .pc_plus4        (pc_plus4),
`ifdef WB_CSR_EN
    .data_csr        (data_csr),
`endif
    .instret_clr     (instret_clr),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .load_misalign   (load_misalign),
    .instret         (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    wb_sel_t    sel;
    logic [2:0] f3;
    logic [1:0] a;
    logic       rw;
    logic [4:0] rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc4;
    logic [31:0] csr;
    logic        we;
    logic [31:0] wdata;
    logic        mis;
    logic        inc;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input wb_sel_t s, input logic [2:0] f3, input logic [1:0] a, input logic rw,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc4, input logic [31:0] csr);
    wb_sel          = s;
    mem_funct3      = f3;
    addr_lo         = a;
    reg_write       = rw;
    rd_addr         = rd;
    data_alu_result = alu;
    data_mem_read   = mem;
    pc_plus4        = pc4;
`ifdef WB_CSR_EN
    data_csr        = csr;
`else
    if (csr == 32'hFFFF_FFFF) pc_plus4 = pc4;
`endif
  endtask

  logic [31:0] csr_exp;

  initial begin
`ifdef WB_CSR_EN
    csr_exp = 32'hCAFE_0000;
`else
    csr_exp = 32'h0000_0011;
`endif
    //           name        sel     f3      a  rw rd  alu           mem           pc4          csr           we  wdata         mis inc
    vecs[0]  = '{"lb_a0",    WB_MEM, F3_LB,  0, 1, 5,  32'h0,        32'h807060F0, 32'h0,       32'h0,        1, 32'hFFFFFFF0, 0, 1};
    vecs[1]  = '{"lhu_a2",   WB_MEM, F3_LHU, 2, 1, 6,  32'h0,        32'h807060F0, 32'h0,       32'h0,        1, 32'h00008070, 0, 1};
    vecs[2]  = '{"lw_a1",    WB_MEM, F3_LW,  1, 1, 7,  32'h0,        32'h807060F0, 32'h0,       32'h0,        0, 32'h807060F0, 1, 0};
    vecs[3]  = '{"pc4_rd0",  WB_PC4, F3_LB,  0, 1, 0,  32'h0,        32'h0,        32'h104,     32'h0,        0, 32'h00000104, 0, 1};
    vecs[4]  = '{"alu_r31",  WB_ALU, F3_LB,  0, 1, 31, 32'h12345678, 32'h0,        32'h0,       32'h0,        1, 32'h12345678, 0, 1};
    vecs[5]  = '{"lb_a3",    WB_MEM, F3_LB,  3, 1, 8,  32'h0,        32'h807060F0, 32'h0,       32'h0,        1, 32'hFFFFFF80, 0, 1};
    vecs[6]  = '{"lbu_a1",   WB_MEM, F3_LBU, 1, 1, 9,  32'h0,        32'h807060F0, 32'h0,       32'h0,        1, 32'h00000060, 0, 1};
    vecs[7]  = '{"lh_a2",    WB_MEM, F3_LH,  2, 1, 10, 32'h0,        32'h807060F0, 32'h0,       32'h0,        1, 32'hFFFF8070, 0, 1};
    vecs[8]  = '{"lh_a0",    WB_MEM, F3_LH,  0, 1, 11, 32'h0,        32'h807060F0, 32'h0,       32'h0,        1, 32'h000060F0, 0, 1};
    vecs[9]  = '{"lh_a1",    WB_MEM, F3_LH,  1, 1, 12, 32'h0,        32'h807060F0, 32'h0,       32'h0,        0, 32'h000060F0, 1, 0};
    vecs[10] = '{"f3_011",   WB_MEM, 3'b011, 0, 1, 13, 32'h0,        32'h807060F0, 32'h0,       32'h0,        1, 32'h00000000, 0, 1};
    vecs[11] = '{"alu_norw", WB_ALU, F3_LB,  0, 0, 3,  32'hA5A5A5A5, 32'h0,        32'h0,       32'h0,        0, 32'hA5A5A5A5, 0, 1};
    vecs[12] = '{"csr_sel",  WB_CSR, F3_LB,  0, 1, 14, 32'h00000011, 32'h0,        32'h0,       32'hCAFE0000, 1, csr_exp,      0, 1};
    vecs[13] = '{"lhu_a3",   WB_MEM, F3_LHU, 3, 1, 15, 32'h0,        32'h807060F0, 32'h0,       32'h0,        0, 32'h00008070, 1, 0};
    vecs[14] = '{"lw_a0",    WB_MEM, F3_LW,  0, 1, 16, 32'h0,        32'h807060F0, 32'h0,       32'h0,        1, 32'h807060F0, 0, 1};

    rst_n       = 1'b1;
    in_valid    = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    instret_clr = 1'b0;
    drive(WB_MEM, F3_LW, 2'd3, 1'b1, 5'd9, 32'h1111, 32'h2222, 32'h3333, 32'h4444);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rf_we", 64'(rf_we), 64'(0));
    chk("rst_rf_waddr", 64'(rf_waddr), 64'(0));
    chk("rst_rf_wdata", 64'(rf_wdata), 64'(0));
    chk("rst_misalign", 64'(load_misalign), 64'(0));
    chk("rst_instret", 64'(instret), 64'(0));
    step();
    step();
    rst_n = 1'b1;
    exp_cnt = '0;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].sel, vecs[i].f3, vecs[i].a, vecs[i].rw, vecs[i].rd,
            vecs[i].alu, vecs[i].mem, vecs[i].pc4, vecs[i].csr);
      in_valid = 1'b1;
      step();
      chk({vecs[i].name, "_we"}, 64'(rf_we), 64'(vecs[i].we));
      chk({vecs[i].name, "_waddr"}, 64'(rf_waddr), 64'(vecs[i].rd));
      chk({vecs[i].name, "_wdata"}, 64'(rf_wdata), 64'(vecs[i].wdata));
      chk({vecs[i].name, "_mis"}, 64'(load_misalign), 64'(vecs[i].mis));
      in_valid = 1'b0;
      step();
      exp_cnt = exp_cnt + CW'(vecs[i].inc);
      chk({vecs[i].name, "_instret"}, 64'(instret), 64'(exp_cnt));
      chk({vecs[i].name, "_once"}, 64'(rf_we), 64'(0));
    end

    // Stall then flush with a valid entry: nothing written or retired.
    drive(WB_ALU, F3_LB, 2'd0, 1'b1, 5'd4, 32'h77, 32'h0, 32'h0, 32'h0);
    in_valid = 1'b1;
    stall    = 1'b1;
    #1 chk("stall_in_ready", 64'(in_ready), 64'(0));
    step();
    chk("stall_we", 64'(rf_we), 64'(0));
    stall = 1'b0;
    flush = 1'b1;
    #1 chk("flush_in_ready", 64'(in_ready), 64'(1));
    step();
    chk("flush_we", 64'(rf_we), 64'(0));
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("stall_flush_instret", 64'(instret), 64'(exp_cnt));

    // Asynchronous reset while an entry is held.
    drive(WB_ALU, F3_LB, 2'd0, 1'b1, 5'd9, 32'hDEAD, 32'h0, 32'h0, 32'h0);
    in_valid = 1'b1;
    step();
    chk("pre_rst_we", 64'(rf_we), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_we", 64'(rf_we), 64'(0));
    chk("async_rst_wdata", 64'(rf_wdata), 64'(0));
    chk("async_rst_waddr", 64'(rf_waddr), 64'(0));
    chk("async_rst_instret", 64'(instret), 64'(0));
    #2 rst_n = 1'b1;
    exp_cnt = '0;
    drive(WB_ALU, F3_LB, 2'd0, 1'b1, 5'd10, 32'h55, 32'h0, 32'h0, 32'h0);
    #1 chk("post_rst_we_idle", 64'(rf_we), 64'(0));
    step();
    chk("resume_we", 64'(rf_we), 64'(1));
    chk("resume_wdata", 64'(rf_wdata), 64'(32'h55));
    in_valid = 1'b0;
    step();
    exp_cnt = exp_cnt + CW'(1);
    chk("resume_instret", 64'(instret), 64'(exp_cnt));

    // Counter clear, wrap through all-ones, and clear coinciding with a retire.
    instret_clr = 1'b1;
    step();
    instret_clr = 1'b0;
    exp_cnt = '0;
    chk("clr_instret", 64'(instret), 64'(exp_cnt));
    in_valid = 1'b1;
    for (int i = 0; i < 15; i++) step();
    in_valid = 1'b0;
    step();
    chk("instret_all_ones", 64'(instret), 64'(4'hF));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("instret_wrap", 64'(instret), 64'(0));
    in_valid = 1'b1;
    step();
    step();
    chk("instret_one", 64'(instret), 64'(1));
    in_valid    = 1'b0;
    instret_clr = 1'b1;
    step();
    instret_clr = 1'b0;
    chk("clr_wins", 64'(instret), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
